// File: rtl/uart_frame_scheduler.sv
// Serializes one framed packet per TDM sample set into a single shared UART
// transmitter: sync byte, then each slot's sample MSB byte first.
module uart_frame_scheduler #(
  parameter int         SLOTS            = 2,
  parameter int         BYTES_PER_SAMPLE = 3,
  parameter logic [7:0] SYNC_BYTE        = 8'hA5,
  parameter int         BUSY_GUARD       = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic        sample_valid_in,
  input  logic [23:0] audio_in1,
  input  logic [23:0] audio_in2,
  input  logic [23:0] audio_in3,
  input  logic [23:0] audio_in4,
  input  logic        uart_busy_in,
  output logic [7:0]  uart_data_out,
  output logic        uart_trigger_out,
  output logic        frame_active_out,
  output logic [15:0] overrun_count_out
);

  localparam int              FRAME_BYTES = 1 + SLOTS * BYTES_PER_SAMPLE;
  localparam logic [3:0]      LAST_IDX    = 4'(FRAME_BYTES - 1);
  localparam logic [3:0]      BPS         = 4'(BYTES_PER_SAMPLE);
  localparam int              GW          = (BUSY_GUARD < 2) ? 1 : $clog2(BUSY_GUARD + 1);
  localparam logic [GW-1:0]   GUARD_LOAD  = GW'(BUSY_GUARD);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] WAIT_TX = 3'd2;
  localparam logic [2:0] GUARD   = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]    state;
  logic [3:0]    byte_idx;
  logic [GW-1:0] guard_cnt;
  logic          prev_valid;
  logic [23:0]   samples [4];
  logic [23:0]   audio_all [4];
  logic [7:0]    data;
  logic          active;
  logic [15:0]   overrun_count;

  logic          sample_edge;
  logic [3:0]    rel_idx;
  logic [1:0]    slot_sel;
  logic [1:0]    byte_sel;
  logic [23:0]   slot_sample;
  logic [7:0]    next_byte;

  assign audio_all[0] = audio_in1;
  assign audio_all[1] = audio_in2;
  assign audio_all[2] = audio_in3;
  assign audio_all[3] = audio_in4;

  assign sample_edge = sample_valid_in & ~prev_valid;

  // Byte k>=1 of the frame is byte (k-1)%BPS of slot (k-1)/BPS; byte 0 is sync.
  always_comb begin
    rel_idx     = byte_idx - 4'd1;
    slot_sel    = 2'(rel_idx / BPS);
    byte_sel    = 2'(rel_idx % BPS);
    slot_sample = samples[slot_sel];
    case (byte_sel)
      2'd0:    next_byte = slot_sample[23:16];
      2'd1:    next_byte = slot_sample[15:8];
      default: next_byte = slot_sample[7:0];
    endcase
    if (byte_idx == 4'd0) next_byte = SYNC_BYTE;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      byte_idx      <= 4'd0;
      guard_cnt     <= '0;
      prev_valid    <= 1'b0;
      data          <= 8'd0;
      active        <= 1'b0;
      overrun_count <= 16'd0;
      for (int i = 0; i < 4; i++) samples[i] <= 24'd0;
    end else begin
      prev_valid <= sample_valid_in;

      // Any new sample set arriving outside IDLE is dropped and counted.
      if (sample_edge && (state != IDLE) && (overrun_count != 16'hFFFF))
        overrun_count <= overrun_count + 16'd1;

      case (state)
        IDLE: begin
          if (sample_edge && enable_in) begin
            for (int i = 0; i < 4; i++) samples[i] <= audio_all[i];
            byte_idx <= 4'd0;
            active   <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          data  <= next_byte;
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (!uart_busy_in) begin
            guard_cnt <= GUARD_LOAD;
            state     <= GUARD;
          end
        end
        GUARD: begin
          // Busy is not trusted until the transmitter has had time to raise it.
          guard_cnt <= guard_cnt - GW'(1);
          if (guard_cnt <= GW'(1)) begin
            if (byte_idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              state    <= LOAD;
            end
          end
        end
        DONE: begin
          if (!uart_busy_in) begin
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign uart_trigger_out  = (state == WAIT_TX) && !uart_busy_in;
  assign uart_data_out     = data;
  assign frame_active_out  = active;
  assign overrun_count_out = overrun_count;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Self-checking bench for uart_frame_scheduler: a busy-handshake transmitter
// model per instance plus a frame-level byte model computed from the samples.
`timescale 1ns/1ps
module tb_uart_frame_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        enable_a = 1'b0, valid_a = 1'b0;
  logic        enable_b = 1'b0, valid_b = 1'b0;
  logic [23:0] a1 = '0, a2 = '0, a3 = '0, a4 = '0;
  logic [23:0] b1 = '0, b2 = '0, b3 = '0, b4 = '0;
  logic        busy_a, busy_b;
  logic [7:0]  data_a, data_b;
  logic        trig_a, trig_b, active_a, active_b;
  logic [15:0] ovr_a, ovr_b;

  int checks = 0;
  int failures = 0;

  uart_frame_scheduler #(.SLOTS(2), .BYTES_PER_SAMPLE(3), .SYNC_BYTE(8'hA5), .BUSY_GUARD(2)) dut_a (
    .clk_in(clk), .rst_in(rst), .enable_in(enable_a), .sample_valid_in(valid_a),
    .audio_in1(a1), .audio_in2(a2), .audio_in3(a3), .audio_in4(a4),
    .uart_busy_in(busy_a), .uart_data_out(data_a), .uart_trigger_out(trig_a),
    .frame_active_out(active_a), .overrun_count_out(ovr_a)
  );

  uart_frame_scheduler #(.SLOTS(2), .BYTES_PER_SAMPLE(1), .SYNC_BYTE(8'hA5), .BUSY_GUARD(2)) dut_b (
    .clk_in(clk), .rst_in(rst), .enable_in(enable_b), .sample_valid_in(valid_b),
    .audio_in1(b1), .audio_in2(b2), .audio_in3(b3), .audio_in4(b4),
    .uart_busy_in(busy_b), .uart_data_out(data_b), .uart_trigger_out(trig_b),
    .frame_active_out(active_b), .overrun_count_out(ovr_b)
  );

  // Transmitter model: busy rises the cycle after a trigger and lasts busy_len cycles.
  int busy_len_a = 1085, busy_len_b = 1085;
  int busy_cnt_a = 0, busy_cnt_b = 0;
  always @(posedge clk) begin
    if (trig_a) busy_cnt_a <= busy_len_a;
    else if (busy_cnt_a > 0) busy_cnt_a <= busy_cnt_a - 1;
    if (trig_b) busy_cnt_b <= busy_len_b;
    else if (busy_cnt_b > 0) busy_cnt_b <= busy_cnt_b - 1;
  end
  assign busy_a = (busy_cnt_a != 0);
  assign busy_b = (busy_cnt_b != 0);

  // Trigger monitor: byte capture, pulse width, spacing and busy-respect.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  int trig_cnt_a = 0, trig_cnt_b = 0, viol = 0;
  int last_trig_a = -100, last_trig_b = -100;
  logic trig_prev_a = 1'b0, trig_prev_b = 1'b0;
  always @(negedge clk) begin
    if (trig_a) begin
      got_a.push_back(data_a);
      trig_cnt_a  <= trig_cnt_a + 1;
      last_trig_a <= cyc;
      if (busy_a || trig_prev_a || (cyc - last_trig_a < 4)) viol <= viol + 1;
    end
    if (trig_b) begin
      got_b.push_back(data_b);
      trig_cnt_b  <= trig_cnt_b + 1;
      last_trig_b <= cyc;
      if (busy_b || trig_prev_b || (cyc - last_trig_b < 4)) viol <= viol + 1;
    end
    trig_prev_a <= trig_a;
    trig_prev_b <= trig_b;
  end

  // Reference frame: sync byte, then each slot's top bps bytes, MSB first.
  logic [7:0] exp_fr [13];
  int exp_len;
  int exp_ovr_a = 0;
  function automatic void build_frame(input int bps, input logic [23:0] s0, input logic [23:0] s1);
    logic [23:0] smp [2];
    smp[0] = s0;
    smp[1] = s1;
    for (int i = 0; i < 13; i++) exp_fr[i] = 8'h00;
    exp_fr[0] = 8'hA5;
    exp_len = 1;
    for (int s = 0; s < 2; s++)
      for (int b = 0; b < bps; b++) begin
        exp_fr[exp_len] = 8'(smp[s] >> (16 - 8 * b));
        exp_len++;
      end
  endfunction

  task automatic launch_a(input logic [23:0] x1, input logic [23:0] x2);
    @(negedge clk);
    a1 = x1; a2 = x2; a3 = 24'($urandom); a4 = 24'($urandom);
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic wait_idle(input bit which_b, input int budget, output bit to, output logic busy_fall);
    to = 1'b1;
    busy_fall = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which_b ? active_b : active_a) == 1'b0) begin
        to = 1'b0;
        busy_fall = which_b ? busy_b : busy_a;
        break;
      end
    end
  endtask

  task automatic wait_trigs_a(input int target, input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (trig_cnt_a >= target) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (data_a !== 8'h00) begin $display("FAIL reset_data_a got=%h exp=00", data_a); failures++; end
    checks++; if (trig_a !== 1'b0) begin $display("FAIL reset_trig_a got=%b exp=0", trig_a); failures++; end
    checks++; if (active_a !== 1'b0) begin $display("FAIL reset_active_a got=%b exp=0", active_a); failures++; end
    checks++; if (ovr_a !== 16'h0) begin $display("FAIL reset_ovr_a got=%h exp=0000", ovr_a); failures++; end
    checks++; if (data_b !== 8'h00 || trig_b !== 1'b0 || active_b !== 1'b0 || ovr_b !== 16'h0) begin
      $display("FAIL reset_b got=%h/%b/%b/%h exp=00/0/0/0000", data_b, trig_b, active_b, ovr_b); failures++; end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (trig_cnt_a !== 0 || trig_cnt_b !== 0) begin
      $display("FAIL reset_no_trigger got=%0d/%0d exp=0/0", trig_cnt_a, trig_cnt_b); failures++; end
    $display("test_reset done");
  endtask

  task automatic test_fixed_frame;
    int base, cbase, vbase, lat;
    bit to;
    logic bf;
    base = got_a.size(); cbase = trig_cnt_a; vbase = viol; lat = -1;
    busy_len_a = 1085;
    enable_a = 1'b1;
    @(negedge clk);
    a1 = 24'h123456; a2 = 24'hABCDEF; valid_a = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) valid_a = 1'b0;
      if (trig_a && lat < 0) lat = i;
    end
    checks++; if (lat !== 2) begin $display("FAIL first_trigger_latency got=%0d exp=2", lat); failures++; end
    wait_idle(1'b0, 12000, to, bf);
    checks++; if (to) begin $display("FAIL fixed_frame_timeout got=active exp=idle"); failures++; end
    checks++; if (bf !== 1'b0) begin $display("FAIL fixed_active_fall_busy got=%b exp=0", bf); failures++; end
    repeat (3) @(negedge clk);
    build_frame(3, 24'h123456, 24'hABCDEF);
    for (int i = 0; i < exp_len; i++) begin
      checks++; if (got_a[base + i] !== exp_fr[i]) begin
        $display("FAIL fixed_byte%0d got=%h exp=%h", i, got_a[base + i], exp_fr[i]); failures++; end
    end
    checks++; if (trig_cnt_a - cbase !== 7) begin $display("FAIL fixed_trig_count got=%0d exp=7", trig_cnt_a - cbase); failures++; end
    checks++; if (ovr_a !== 16'd0) begin $display("FAIL fixed_overrun got=%h exp=0000", ovr_a); failures++; end
    checks++; if (viol !== vbase) begin $display("FAIL fixed_trigger_rules got=%0d exp=%0d", viol, vbase); failures++; end
    $display("test_fixed_frame bytes=%0d", trig_cnt_a - cbase);
  endtask

  task automatic test_overrun;
    int base, cbase;
    bit to;
    logic bf;
    logic [23:0] x1, x2, y1, y2;
    x1 = 24'($urandom); x2 = 24'($urandom); y1 = 24'($urandom); y2 = 24'($urandom);
    busy_len_a = 1085;
    base = got_a.size(); cbase = trig_cnt_a;
    launch_a(x1, x2);
    repeat (3198) @(negedge clk);
    a1 = y1; a2 = y2; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    exp_ovr_a++;
    repeat (2) @(negedge clk);
    checks++; if (ovr_a !== 16'(exp_ovr_a)) begin $display("FAIL overrun_count got=%h exp=%h", ovr_a, 16'(exp_ovr_a)); failures++; end
    wait_idle(1'b0, 12000, to, bf);
    checks++; if (to) begin $display("FAIL overrun_frame_timeout got=active exp=idle"); failures++; end
    repeat (3) @(negedge clk);
    build_frame(3, x1, x2);
    for (int i = 0; i < exp_len; i++) begin
      checks++; if (got_a[base + i] !== exp_fr[i]) begin
        $display("FAIL overrun_byte%0d got=%h exp=%h", i, got_a[base + i], exp_fr[i]); failures++; end
    end
    checks++; if (trig_cnt_a - cbase !== 7) begin $display("FAIL overrun_trig_count got=%0d exp=7", trig_cnt_a - cbase); failures++; end
    base = got_a.size(); cbase = trig_cnt_a;
    busy_len_a = 30;
    launch_a(y1, y2);
    wait_idle(1'b0, 2000, to, bf);
    repeat (3) @(negedge clk);
    build_frame(3, y1, y2);
    for (int i = 0; i < exp_len; i++) begin
      checks++; if (got_a[base + i] !== exp_fr[i]) begin
        $display("FAIL next_frame_byte%0d got=%h exp=%h", i, got_a[base + i], exp_fr[i]); failures++; end
    end
    $display("test_overrun overrun=%0d", ovr_a);
  endtask

  task automatic test_enable;
    int base, cbase;
    bit to;
    logic bf;
    logic [23:0] x1, x2;
    cbase = trig_cnt_a;
    enable_a = 1'b0;
    launch_a(24'($urandom), 24'($urandom));
    repeat (30) @(negedge clk);
    checks++; if (trig_cnt_a !== cbase || active_a !== 1'b0) begin
      $display("FAIL disabled_edge got=trigs%0d/active%b exp=0/0", trig_cnt_a - cbase, active_a); failures++; end
    checks++; if (ovr_a !== 16'(exp_ovr_a)) begin $display("FAIL disabled_overrun got=%h exp=%h", ovr_a, 16'(exp_ovr_a)); failures++; end
    enable_a = 1'b1;
    busy_len_a = int'($urandom_range(20, 60));
    x1 = 24'($urandom); x2 = 24'($urandom);
    base = got_a.size(); cbase = trig_cnt_a;
    launch_a(x1, x2);
    wait_trigs_a(cbase + 2, 500, to);
    checks++; if (to) begin $display("FAIL enable_drop_wait got=%0d exp=2", trig_cnt_a - cbase); failures++; end
    enable_a = 1'b0;
    wait_idle(1'b0, 2000, to, bf);
    enable_a = 1'b1;
    repeat (3) @(negedge clk);
    build_frame(3, x1, x2);
    for (int i = 0; i < exp_len; i++) begin
      checks++; if (got_a[base + i] !== exp_fr[i]) begin
        $display("FAIL enable_drop_byte%0d got=%h exp=%h", i, got_a[base + i], exp_fr[i]); failures++; end
    end
    checks++; if (trig_cnt_a - cbase !== 7) begin $display("FAIL enable_drop_count got=%0d exp=7", trig_cnt_a - cbase); failures++; end
    $display("test_enable bytes=%0d", trig_cnt_a - cbase);
  endtask

  task automatic test_random_frames;
    int base, cbase, vbase;
    bit done;
    logic [23:0] x1, x2;
    vbase = viol;
    for (int f = 0; f < 6; f++) begin
      x1 = 24'($urandom); x2 = 24'($urandom);
      busy_len_a = int'($urandom_range(8, 60));
      base = got_a.size(); cbase = trig_cnt_a;
      enable_a = 1'b1;
      launch_a(x1, x2);
      done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
        @(negedge clk);
        a1 = 24'($urandom); a2 = 24'($urandom);
        enable_a = 1'($urandom_range(0, 1));
        if (!valid_a && (trig_cnt_a - cbase >= 1) && (trig_cnt_a - cbase < 6) && ($urandom_range(0, 15) == 0)) begin
          valid_a = 1'b1;
          exp_ovr_a++;
        end else begin
          valid_a = 1'b0;
        end
        if (active_a == 1'b0) done = 1'b1;
      end
      valid_a = 1'b0;
      enable_a = 1'b1;
      checks++; if (!done) begin $display("FAIL random%0d_timeout got=active exp=idle", f); failures++; end
      repeat (3) @(negedge clk);
      build_frame(3, x1, x2);
      for (int i = 0; i < exp_len; i++) begin
        checks++; if (got_a[base + i] !== exp_fr[i]) begin
          $display("FAIL random%0d_byte%0d got=%h exp=%h", f, i, got_a[base + i], exp_fr[i]); failures++; end
      end
      checks++; if (trig_cnt_a - cbase !== 7) begin $display("FAIL random%0d_count got=%0d exp=7", f, trig_cnt_a - cbase); failures++; end
      checks++; if (ovr_a !== 16'(exp_ovr_a)) begin $display("FAIL random%0d_overrun got=%h exp=%h", f, ovr_a, 16'(exp_ovr_a)); failures++; end
      $display("test_random_frames frame=%0d busy_len=%0d overrun=%0d", f, busy_len_a, ovr_a);
    end
    checks++; if (viol !== vbase) begin $display("FAIL random_trigger_rules got=%0d exp=%0d", viol, vbase); failures++; end
  endtask

  task automatic test_single_byte_slots;
    int base, cbase;
    bit to;
    logic bf;
    base = got_b.size(); cbase = trig_cnt_b;
    busy_len_b = 1085;
    enable_b = 1'b1;
    @(negedge clk);
    b1 = 24'h7F0000; b2 = 24'h800000; b3 = 24'($urandom); b4 = 24'($urandom); valid_b = 1'b1;
    @(negedge clk);
    valid_b = 1'b0;
    wait_idle(1'b1, 6000, to, bf);
    checks++; if (to) begin $display("FAIL bps1_timeout got=active exp=idle"); failures++; end
    repeat (3) @(negedge clk);
    build_frame(1, 24'h7F0000, 24'h800000);
    for (int i = 0; i < exp_len; i++) begin
      checks++; if (got_b[base + i] !== exp_fr[i]) begin
        $display("FAIL bps1_byte%0d got=%h exp=%h", i, got_b[base + i], exp_fr[i]); failures++; end
    end
    checks++; if (trig_cnt_b - cbase !== 3) begin $display("FAIL bps1_count got=%0d exp=3", trig_cnt_b - cbase); failures++; end
    checks++; if (ovr_b !== 16'd0) begin $display("FAIL bps1_overrun got=%h exp=0000", ovr_b); failures++; end
    $display("test_single_byte_slots bytes=%0d", trig_cnt_b - cbase);
  endtask

  task automatic test_reset_mid_frame;
    int base, cbase;
    bit to;
    logic bf;
    logic [23:0] x1, x2;
    busy_len_a = 40;
    cbase = trig_cnt_a;
    launch_a(24'($urandom), 24'($urandom));
    wait_trigs_a(cbase + 4, 1000, to);
    checks++; if (to) begin $display("FAIL reset_mid_wait got=%0d exp=4", trig_cnt_a - cbase); failures++; end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (data_a !== 8'h00 || trig_a !== 1'b0) begin
      $display("FAIL async_reset_data got=%h/%b exp=00/0", data_a, trig_a); failures++; end
    checks++; if (active_a !== 1'b0 || ovr_a !== 16'h0) begin
      $display("FAIL async_reset_state got=%b/%h exp=0/0000", active_a, ovr_a); failures++; end
    exp_ovr_a = 0;
    @(negedge clk);
    rst = 1'b0;
    cbase = trig_cnt_a;
    repeat (100) @(negedge clk);
    checks++; if (trig_cnt_a !== cbase || active_a !== 1'b0) begin
      $display("FAIL post_reset_quiet got=trigs%0d/active%b exp=0/0", trig_cnt_a - cbase, active_a); failures++; end
    x1 = 24'($urandom); x2 = 24'($urandom);
    base = got_a.size();
    launch_a(x1, x2);
    wait_idle(1'b0, 2000, to, bf);
    repeat (3) @(negedge clk);
    build_frame(3, x1, x2);
    for (int i = 0; i < exp_len; i++) begin
      checks++; if (got_a[base + i] !== exp_fr[i]) begin
        $display("FAIL post_reset_byte%0d got=%h exp=%h", i, got_a[base + i], exp_fr[i]); failures++; end
    end
    checks++; if (trig_cnt_a - cbase !== 7) begin $display("FAIL post_reset_count got=%0d exp=7", trig_cnt_a - cbase); failures++; end
    $display("test_reset_mid_frame bytes=%0d", trig_cnt_a - cbase);
  endtask

  task automatic test_saturation;
    busy_len_a = 1085;
    launch_a(24'($urandom), 24'($urandom));
    repeat (10) @(negedge clk);
    force dut_a.overrun_count = 16'hFFFE;
    #1;
    release dut_a.overrun_count;
    @(negedge clk);
    checks++; if (ovr_a !== 16'hFFFE) begin $display("FAIL sat_preload got=%h exp=fffe", ovr_a); failures++; end
    for (int e = 0; e < 3; e++) begin
      valid_a = 1'b1;
      @(negedge clk);
      valid_a = 1'b0;
      @(negedge clk);
      checks++; if (ovr_a !== 16'hFFFF) begin $display("FAIL sat_edge%0d got=%h exp=ffff", e, ovr_a); failures++; end
    end
    $display("test_saturation overrun=%h", ovr_a);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_fixed_frame();
    test_overrun();
    test_enable();
    test_random_frames();
    test_single_byte_slots();
    test_reset_mid_frame();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_scheduler.md
Name: uart_frame_scheduler

Overview:
Sequences the shared 921.6 kbaud UART transmitter among the TDM microphone slots. On each new TDM sample set, it latches all slot samples and emits one framed packet: a sync byte, then each slot's sample MSB-first. It drives the trigger/data inputs of uart_transmit and obeys its busy handshake. Frames are never torn. Samples that arrive while a frame is in flight are dropped and counted.

Parameters:
SLOTS, 2, number of mic slots serialized per frame (1..4); slots 1..SLOTS are sent in ascending order.
BYTES_PER_SAMPLE, 3, bytes sent per slot (1..3), taken from the top of the 24-bit sample, MSB byte first.
SYNC_BYTE, 8'hA5, first byte of every frame.
BUSY_GUARD, 2, cycles after a trigger during which busy_in is ignored, covering transmitter busy-assert latency.

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  asynchronous active-high reset
enable_in  input  1  frame start permitted (sw[0]); sampled only in IDLE
sample_valid_in  input  1  TDM audio_valid level; a rising edge marks a new sample set
audio_in1..audio_in4  input  24 each  slot samples; valid at the rising edge of sample_valid_in
uart_busy_in  input  1  busy_out from uart_transmit
uart_data_out  output  8  byte to uart_transmit data_byte_in
uart_trigger_out  output  1  single-cycle pulse to uart_transmit trigger_in
frame_active_out  output  1  high from frame start until the last byte is accepted and busy has dropped
overrun_count_out  output  16  count of dropped sample sets, saturating

Behaviour:
- Reset (asynchronous, immediate): state IDLE; uart_data_out=0, uart_trigger_out=0, frame_active_out=0, overrun_count_out=0; sample latches=0; edge-detect register=0. A reset mid-frame abandons the frame. No trailing trigger is issued after reset releases.
- Edge detect: register prev <= sample_valid_in every cycle. Edge = sample_valid_in & ~prev.
- States: IDLE, LOAD, WAIT_TX, GUARD, DONE.
- IDLE:
  - Edge & enable_in: latch audio_in1..SLOTS, set byte index=0, go LOAD, frame_active_out=1 next cycle.
  - Edge & ~enable_in: ignored; not an overrun.
- LOAD: select the byte for the current index.
  - Index 0 is SYNC_BYTE.
  - Index k≥1 maps to slot s=(k-1)/BYTES_PER_SAMPLE+1 and byte b=(k-1)%BYTES_PER_SAMPLE, where b=0 is bits[23:16], b=1 is [15:8], b=2 is [7:0].
  - Present the byte on uart_data_out. Go WAIT_TX.
- WAIT_TX:
  - When uart_busy_in==0: pulse uart_trigger_out for exactly one cycle with uart_data_out stable that cycle, load guard counter=BUSY_GUARD, go GUARD.
  - uart_data_out holds its value until the next LOAD.
- GUARD: busy ignored; decrement the counter. At 0:
  - If index==1+SLOTS*BYTES_PER_SAMPLE-1, go DONE.
  - Otherwise increment index and go LOAD.
- DONE: wait for uart_busy_in==0, then frame_active_out=0 and go IDLE.
- Frame length is 1+SLOTS*BYTES_PER_SAMPLE bytes, with exactly that many trigger pulses per frame.
- Latency: with busy low, the edge is seen at cycle N and the first trigger fires at N+2 (LOAD at N+1, WAIT_TX at N+2).
- Overrun: an edge in any state other than IDLE increments overrun_count_out, saturating at 16'hFFFF. The sample is dropped and the in-flight frame is unaffected.
- An edge in the same cycle as the DONE→IDLE transition counts as an overrun.
- enable_in falling mid-frame has no effect; the frame completes. A new frame needs enable_in high in IDLE.
- Latched samples are immune to audio_in changes during the frame.
- At most one trigger pulse is issued per BUSY_GUARD+2 cycles, and never while busy is observed high outside GUARD.

Test Plan:
- SLOTS=2, BPS=3, busy model asserts busy 1 cycle after trigger for 1085 cycles; audio_in1=24'h123456, audio_in2=24'hABCDEF, one valid edge -> bytes A5,12,34,56,AB,CD,EF, 7 single-cycle triggers, first trigger 2 cycles after the edge, frame_active_out falls after the final busy drop, overrun_count_out=0.
- Second valid edge 3200 cycles into the frame -> frame unchanged, overrun_count_out=1, no new frame until IDLE; the next edge after IDLE starts a frame with the new samples.
- enable_in=0 at the edge -> no triggers, overrun_count_out stays 0. enable_in dropped after the 2nd byte -> all 7 bytes are still sent.
- BPS=1, SLOTS=2, samples 24'h7F0000 and 24'h800000 -> bytes A5,7F,80 only; 3 triggers.
- rst_in asserted asynchronously mid-byte 4 -> outputs 0 within the same cycle, state IDLE; no trigger after release until a fresh edge with enable_in high.
- Force overrun_count to FFFE, then apply 3 overrun edges -> saturates at FFFF with no wrap.
